// File: rtl/matrix_ram_sequencer.sv
// matrix_ram_sequencer: sole RAM master for one 3x3 matrix product.
// Streams A and B into the datapath, kicks it, and writes the nine results back.
module matrix_ram_sequencer #(
    parameter int A_BASE  = 0,
    parameter int B_BASE  = 9,
    parameter int C_BASE  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] ram_q,
    output logic [6:0]  ram_addr,
    output logic [31:0] ram_data,
    output logic        ram_we,
    output logic        mx_load,
    output logic        mx_sel,
    output logic [3:0]  mx_idx,
    output logic [31:0] mx_operand,
    output logic        mx_start,
    input  logic        mx_busy,
    input  logic        mx_done,
    input  logic [31:0] mx_result,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_A = 3'd1;
    localparam logic [2:0] LOAD_B = 3'd2;
    localparam logic [2:0] KICK   = 3'd3;
    localparam logic [2:0] WAIT   = 3'd4;
    localparam logic [2:0] STORE  = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;
    localparam logic [2:0] ERR    = 3'd7;

    logic [2:0] state;
    logic [3:0] idx;
    logic [7:0] timer;
    logic       last;

    assign last = idx == 4'd8;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            idx   <= 4'd0;
            timer <= 8'd0;
        end else begin
            case (state)
                IDLE, ERR: if (start) begin
                    state <= LOAD_A;
                    idx   <= 4'd0;
                end
                LOAD_A: begin
                    idx <= last ? 4'd0 : idx + 4'd1;
                    if (last) state <= LOAD_B;
                end
                LOAD_B: begin
                    idx <= last ? 4'd0 : idx + 4'd1;
                    if (last) state <= KICK;
                end
                KICK: if (!mx_busy) begin
                    timer <= 8'd0;
                    state <= WAIT;
                end
                WAIT: if (mx_done) begin
                    idx   <= 4'd0;
                    state <= STORE;
                end else begin
                    timer <= timer + 8'd1;
                    if (timer == 8'(TIMEOUT - 1)) state <= ERR;
                end
                STORE: begin
                    idx <= last ? 4'd0 : idx + 4'd1;
                    if (last) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of state so reset forces them all to 0 at once.
    assign mx_load    = state == LOAD_A || state == LOAD_B;
    assign mx_sel     = state == LOAD_B;
    assign ram_we     = state == STORE;
    assign ram_addr   = state == LOAD_A ? 7'(A_BASE) + {3'b000, idx} :
                        state == LOAD_B ? 7'(B_BASE) + {3'b000, idx} :
                        ram_we          ? 7'(C_BASE) + {3'b000, idx} : 7'd0;
    assign mx_idx     = (mx_load || ram_we) ? idx : 4'd0;
    assign mx_operand = mx_load ? ram_q : 32'd0;
    assign ram_data   = ram_we ? mx_result : 32'd0;
    assign mx_start   = state == KICK && !mx_busy;
    assign busy       = state != IDLE && state != ERR;
    assign done       = state == DONE;
    assign err        = state == ERR;
endmodule

// File: tb/tb_matrix_ram_sequencer.sv
// tb_matrix_ram_sequencer: randomized bench with a cycle-schedule reference model,
// a behavioural RAM and a behavioural 3x3 multiply datapath.
module tb_matrix_ram_sequencer;
    localparam int CB = 124;
    localparam int TO = 20;
    typedef logic [31:0] mat_t [9];

    logic clk = 1'b0;
    logic clr, start, ram_we, mx_load, mx_sel, mx_start, mx_busy, mx_done, busy, done, err;
    logic [6:0]  ram_addr;
    logic [3:0]  mx_idx;
    logic [31:0] ram_q, ram_data, mx_operand, mx_result;

    always #5 clk = ~clk;

    matrix_ram_sequencer #(.C_BASE(CB), .TIMEOUT(TO)) dut (
        .clk(clk), .clr(clr), .start(start), .ram_q(ram_q), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_we(ram_we), .mx_load(mx_load), .mx_sel(mx_sel),
        .mx_idx(mx_idx), .mx_operand(mx_operand), .mx_start(mx_start), .mx_busy(mx_busy),
        .mx_done(mx_done), .mx_result(mx_result), .busy(busy), .done(done), .err(err)
    );

    function automatic mat_t mul(input mat_t x, input mat_t y);
        mat_t r;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                r[i*3+j] = 32'd0;
                for (int k = 0; k < 3; k++) r[i*3+j] += x[i*3+k] * y[k*3+j];
            end
        return r;
    endfunction

    int total = 0, bad = 0;
    task automatic chk(input string n, input int t, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s t=%0d got=%0h want=%0h", n, t, a, e);
        end
    endtask

    // RAM with combinational read and write on the rising edge
    logic [31:0] ram [128];
    assign ram_q = ram[ram_addr];
    always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_data;

    // Datapath model: captures operands, holds busy h cycles, raises done lat cycles after kick
    mat_t a, b, c;
    int h = 0, lat = 0, busy_cnt = 0, dcnt = 0;
    logic pend = 1'b0, spur = 1'b0;
    always_comb c = mul(a, b);
    assign mx_result = (mx_idx < 4'd9) ? c[mx_idx] : 32'd0;
    assign mx_busy = busy_cnt > 0;
    assign mx_done = spur || (pend && dcnt == 0);
    always @(posedge clk) begin
        if (mx_load && !mx_sel) a[mx_idx] <= mx_operand;
        if (mx_load && mx_sel) b[mx_idx] <= mx_operand;
        if (mx_load && mx_sel && mx_idx == 4'd8) busy_cnt <= h;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        if (!clr || done) pend <= 1'b0;
        else if (mx_start) begin
            pend <= 1'b1;
            dcnt <= lat;
        end else if (dcnt > 0) dcnt <= dcnt - 1;
    end

    // Schedule model: every output as a function of cycles since start was sampled
    int cyc = 0, t0 = 0;
    bit op_on = 1'b0;
    logic [31:0] snap [128];
    mat_t expc;
    int done_t, start_t, err_t, we_cnt, ld_cnt;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : cmp
        int t, w, e, li, si;
        bit ld, sl, st, ks, dn, bz, er;
        logic [6:0]  ad;
        logic [3:0]  ix;
        logic [31:0] op, dt;
        t  = cyc - t0;
        w  = 20 + h + lat;
        e  = 20 + h + TO;
        ld = op_on && t >= 1 && t <= 18;
        sl = ld && t >= 10;
        li = sl ? t - 10 : t - 1;
        st = op_on && lat >= 0 && t > w && t <= w + 9;
        si = t - w - 1;
        ks = op_on && t == 19 + h;
        dn = op_on && lat >= 0 && t == w + 10;
        bz = op_on && t >= 1 && (lat >= 0 ? t <= w + 10 : t < e);
        er = op_on && lat < 0 && t >= e;
        ad = ld ? 7'((sl ? 9 : 0) + li) : st ? 7'(CB + si) : 7'd0;
        ix = ld ? 4'(li) : st ? 4'(si) : 4'd0;
        op = ld ? snap[ad] : 32'd0;
        dt = st ? expc[si] : 32'd0;
        chk("ram_addr", t, 32'(ram_addr), 32'(ad));
        chk("ram_we", t, 32'(ram_we), 32'(st));
        chk("ram_data", t, ram_data, dt);
        chk("mx_load", t, 32'(mx_load), 32'(ld));
        chk("mx_sel", t, 32'(mx_sel), 32'(sl));
        chk("mx_idx", t, 32'(mx_idx), 32'(ix));
        chk("mx_operand", t, mx_operand, op);
        chk("mx_start", t, 32'(mx_start), 32'(ks));
        chk("busy", t, 32'(busy), 32'(bz));
        chk("done", t, 32'(done), 32'(dn));
        chk("err", t, 32'(err), 32'(er));
        if (done) done_t = t;
        if (mx_start) start_t = t;
        if (err && err_t < 0) err_t = t;
        we_cnt += int'(ram_we);
        ld_cnt += int'(mx_load);
    end

    task automatic run_op(input int hh, input int ll, input int abort_at, input bit spurious);
        int w, tend, tt, nw;
        logic [31:0] exp_ram [128];
        mat_t sa, sb;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 128; i++) snap[i] = ram[i];
        for (int i = 0; i < 9; i++) begin
            sa[i] = snap[i];
            sb[i] = snap[9+i];
        end
        expc = mul(sa, sb);
        h = hh; lat = ll; t0 = cyc - 1; op_on = 1'b1;
        done_t = -1; start_t = -1; err_t = -1; we_cnt = 0; ld_cnt = 0;
        w = 20 + hh + ll;
        tend = ll >= 0 ? w + 12 : 20 + hh + TO + 3;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            tt = cyc - t0;
            if (spurious) begin
                spur  = tt == 3 || tt == 4;
                start = tt == 11 || tt == 13;
            end
            if (abort_at > 0 && tt == w + 1 + abort_at) begin
                clr = 1'b0;
                op_on = 1'b0;
                #1;
                chk("async_we", tt, 32'(ram_we), 32'd0);
                chk("async_busy", tt, 32'(busy), 32'd0);
                chk("async_addr", tt, 32'(ram_addr), 32'd0);
                break;
            end
            if (tt >= tend) break;
            if (n == 199) chk("op_bound", tt, 32'(tt), 32'(tend));
        end
        spur = 1'b0;
        start = 1'b0;
        nw = abort_at > 0 ? abort_at : (ll >= 0 ? 9 : 0);
        for (int i = 0; i < 128; i++) exp_ram[i] = snap[i];
        for (int i = 0; i < nw; i++) exp_ram[(CB + i) % 128] = expc[i];
        for (int i = 0; i < 128; i++) chk("ram", i, ram[i], exp_ram[i]);
        chk("we_cnt", 0, 32'(we_cnt), 32'(nw));
        chk("ld_cnt", 0, 32'(ld_cnt), 32'd18);
        if (abort_at > 0) begin
            @(posedge clk); #1 clr = 1'b1;
        end
    endtask

    task automatic rnd_ab();
        for (int i = 0; i < 18; i++) ram[i] <= $urandom;
    endtask

    initial begin
        clr = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 128; i++) ram[i] <= $urandom;
        for (int i = 0; i < 9; i++) begin
            ram[i]   <= 32'(i + 1);
            ram[9+i] <= (i % 4 == 0) ? 32'd1 : 32'd0;
        end
        repeat (3) @(posedge clk);
        #1 clr = 1'b1;
        repeat (2) @(posedge clk);
        // Nominal: identity B, result lands 3 cycles late
        run_op(0, 3, -1, 1'b0);
        chk("nom_done_t", 0, 32'(done_t), 32'd33);
        for (int i = 0; i < 9; i++) chk("nom_c", i, ram[(CB + i) % 128], 32'(i + 1));
        // Busy hold with spurious start/done
        rnd_ab();
        run_op(5, 1, -1, 1'b1);
        chk("hold_start_t", 0, 32'(start_t), 32'd24);
        // Timeout, then restart straight out of ERR
        rnd_ab();
        run_op(0, -1, -1, 1'b0);
        chk("to_err_t", 0, 32'(err_t), 32'd40);
        chk("to_busy", 0, 32'(busy), 32'd0);
        chk("to_err", 0, 32'(err), 32'd1);
        run_op(2, 0, -1, 1'b0);
        chk("rec_err_t", 0, 32'(err_t), 32'hffff_ffff);
        // Reset after the 4th write, then a clean run
        rnd_ab();
        run_op(1, 2, 4, 1'b0);
        rnd_ab();
        run_op(0, 0, -1, 1'b0);
        chk("min_done_t", 0, 32'(done_t), 32'd30);
        for (int k = 0; k < 4; k++) begin
            rnd_ab();
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), -1, 1'($urandom_range(0, 1)));
        end
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
